// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback-to-operand bypass (optional, macro ID_EX_WB_BYPASS_EN) and bubble counter.
// Latency: one CLK edge from decode inputs to Ex* outputs.
// Backpressure: Flush inserts a bubble over Stall; Stall holds contents, only the held operands may be refreshed by bypass.
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [31:0]       PCIn,
    input  logic [31:0]       ImmIn,
    input  logic [4:0]        RsIn,
    input  logic [4:0]        RtIn,
    input  logic [4:0]        RdIn,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic [31:0]       RDataA,
    input  logic [31:0]       RDataB,
    input  logic              WBWEn,
    input  logic [4:0]        WBRDest,
    input  logic [31:0]       WBWData,
    output logic              ExValid,
    output logic [31:0]       ExPC,
    output logic [31:0]       ExImm,
    output logic [4:0]        ExRs,
    output logic [4:0]        ExRt,
    output logic [4:0]        ExRd,
    output logic [CTRL_W-1:0] ExCtrl,
    output logic [31:0]       ExA,
    output logic [31:0]       ExB,
    output logic [15:0]       BubbleCount
);

    logic load_byp_a;
    logic load_byp_b;
    logic hold_byp_a;
    logic hold_byp_b;
    logic bubble;

`ifdef ID_EX_WB_BYPASS_EN
    logic wb_live;

    // Register 0 is hardwired, so a writeback to it must never be forwarded.
    always_comb begin
        wb_live    = WBWEn && (WBRDest != 5'd0);
        load_byp_a = wb_live && (WBRDest == RsIn);
        load_byp_b = wb_live && (WBRDest == RtIn);
        hold_byp_a = wb_live && ExValid && (WBRDest == ExRs);
        hold_byp_b = wb_live && ExValid && (WBRDest == ExRt);
    end
`else
    logic unused_wb;

    always_comb begin
        load_byp_a = 1'b0;
        load_byp_b = 1'b0;
        hold_byp_a = 1'b0;
        hold_byp_b = 1'b0;
        unused_wb  = ^{WBWEn, WBRDest, WBWData};
    end
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ExValid <= 1'b0;
            ExPC    <= '0;
            ExImm   <= '0;
            ExRs    <= '0;
            ExRt    <= '0;
            ExRd    <= '0;
            ExCtrl  <= '0;
            ExA     <= '0;
            ExB     <= '0;
        end else if (Flush) begin
            ExValid <= 1'b0;
            ExPC    <= '0;
            ExImm   <= '0;
            ExRs    <= '0;
            ExRt    <= '0;
            ExRd    <= '0;
            ExCtrl  <= '0;
            ExA     <= '0;
            ExB     <= '0;
        end else if (Stall) begin
            if (hold_byp_a) ExA <= WBWData;
            if (hold_byp_b) ExB <= WBWData;
        end else begin
            ExValid <= InValid;
            ExPC    <= PCIn;
            ExImm   <= ImmIn;
            ExRs    <= RsIn;
            ExRt    <= RtIn;
            ExRd    <= RdIn;
            ExCtrl  <= InValid ? CtrlIn : '0;
            ExA     <= load_byp_a ? WBWData : RDataA;
            ExB     <= load_byp_b ? WBWData : RDataB;
        end
    end

    // A bubble is a flush or an invalid slot loaded into execute; stalls do not count.
    assign bubble = Flush || (!Stall && !InValid);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            BubbleCount <= '0;
        end else if (bubble && (BubbleCount != 16'hFFFF)) begin
            BubbleCount <= BubbleCount + 16'd1;
        end
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of the decoded control bundle.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RSTn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port Stall  input  1  hold all pipeline contents this cycle.
REQ-005 SHALL have port Flush  input  1  insert bubble this cycle.
REQ-006 SHALL have port InValid  input  1  decode-stage instruction valid.
REQ-007 SHALL have ports PCIn  input  32; ImmIn  input  32  decode PC and sign-extended immediate.
REQ-008 SHALL have ports RsIn, RtIn, RdIn  input  5 each  decoded register indices.
REQ-009 SHALL have port CtrlIn  input  CTRL_W  decoded control bundle.
REQ-010 SHALL have ports RDataA, RDataB  input  32 each  register-file read data for RsIn/RtIn.
REQ-011 SHALL have ports WBWEn  input  1; WBRDest  input  5; WBWData  input  32  same-cycle writeback into the register file.
REQ-012 SHALL have outputs ExValid 1, ExPC 32, ExImm 32, ExRs 5, ExRt 5, ExRd 5, ExCtrl CTRL_W, ExA 32, ExB 32  registered execute-stage operands.
REQ-013 SHALL have output BubbleCount  16  count of bubbles entering execute.

Function
REQ-014 SHALL update all outputs only on CLK rising edge (except reset); single-cycle latency from inputs to outputs.
REQ-015 SHALL apply priority Flush > Stall > Load each cycle.
REQ-016 Flush SHALL set ExValid=0, ExCtrl=0 and all other Ex* outputs to 0, regardless of Stall.
REQ-017 Stall (no Flush) SHALL hold every Ex* output except the bypass update of REQ-021.
REQ-018 Load (no Flush, no Stall) SHALL capture PCIn, ImmIn, RsIn, RtIn, RdIn; ExValid<=InValid; ExCtrl<=CtrlIn if InValid else 0.
REQ-019 Load SHALL set ExA<=RDataA, ExB<=RDataB unless overridden by REQ-020.
REQ-020 Load SHALL apply independent bypass per operand: ExA<=WBWData if WBWEn=1, WBRDest!=0, WBRDest==RsIn; same for ExB with RtIn; both operands may bypass in one cycle.
REQ-021 Stall with ExValid=1 SHALL apply bypass to held operands: ExA<=WBWData if WBWEn=1, WBRDest!=0, WBRDest==ExRs; same for ExB/ExRt.
REQ-022 Index 0 SHALL never be bypassed; read data for register 0 passes unchanged.
REQ-023 BubbleCount SHALL increment by 1 on every edge where a Flush occurs or a Load occurs with InValid=0; SHALL saturate at 16'hFFFF; Stall cycles SHALL not count.

Reset
REQ-024 RSTn=0 SHALL immediately, independent of CLK, clear every output to 0 (ExValid=0, BubbleCount=0).
REQ-025 Reset mid-stall or mid-flush SHALL discard held contents; first edge after RSTn release SHALL behave as a normal cycle.

Configuration
REQ-026 Macro ID_EX_WB_BYPASS_EN defined SHALL enable REQ-020/REQ-021 bypass logic.
REQ-027 Macro ID_EX_WB_BYPASS_EN undefined SHALL remove bypass: Load always captures RDataA/RDataB, Stall holds ExA/ExB unchanged; all other behaviour identical.

Verification
REQ-028 Reset: RSTn=0 between edges -> all outputs 0 before next edge; release, Load InValid=1 PCIn=32'h40 -> ExPC=32'h40, ExValid=1 after one edge.
REQ-029 Bypass on load (macro on): RsIn=5, RtIn=5, RDataA=RDataB=5, WBWEn=1, WBRDest=5, WBWData=32'hDEAD -> ExA=ExB=32'hDEAD; macro off -> ExA=ExB=5.
REQ-030 Register 0: RsIn=0, WBWEn=1, WBRDest=0, WBWData=32'h1234, RDataA=0 -> ExA=0.
REQ-031 Stall bypass: load ExRs=7 ExA=7, then Stall=1 with WBWEn=1 WBRDest=7 WBWData=32'h99 -> ExA=32'h99, ExPC/ExCtrl unchanged; Stall with WBRDest=8 -> ExA unchanged.
REQ-032 Flush+Stall same cycle -> ExValid=0, ExCtrl=0, BubbleCount+1; Stall alone for 3 cycles -> BubbleCount unchanged.
REQ-033 Saturation: force 65535 bubble events then one more Flush -> BubbleCount stays 16'hFFFF.
